decrypt_iterative: RTL and testbench
====================================

// Module: decrypt_iterative
// PURPOSE
//  Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256, selected by parameter.
//  Receive-side counterpart of the iterative encryptor: takes a ciphertext block and cipher key
//  and returns the plaintext. Uses one inverse round datapath and a word-serial key schedule.
//  Port names and the start/done protocol match the encryptor, so both are drop-in pairs.
// PARAMETERS
//  KEY_LEN  128  cipher key width in bits (128/192/256)
//  Nr       10   number of rounds (10/12/14)
//  Nk       4    key length in 32-bit words (4/6/8)
// PORTS
//  clk    in   1        clock, rising edge
//  rst    in   1        asynchronous, active-high reset
//  start  in   1        level request; held high for the whole operation, low aborts/clears
//  in     in   128      ciphertext block, big-endian (byte 0 = in[127:120])
//  key    in   KEY_LEN  cipher key, big-endian; word w[0] = key[KEY_LEN-1 -: 32]
//  out    out  128      plaintext block
//  done   out  1        high while out holds a valid result for the current request
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, out=0, done=0, round counter=0, word index=0.
//  FSM: IDLE -> LOAD -> EXPAND -> ADDKEY -> ROUND -> DONE.
//   IDLE:   done=0; on a clk edge with start=1 go to LOAD.
//   LOAD:   latch in into state register and key words w[0..Nk-1]; exactly 1 cycle.
//   EXPAND: one word per cycle, i = Nk .. 4*(Nr+1)-1:
//           t=w[i-1]; if i%Nk==0 t=SubWord(RotWord(t))^Rcon[i/Nk];
//           else if Nk>6 && i%Nk==4 t=SubWord(t); w[i]=w[i-Nk]^t.
//   ADDKEY: state ^= rk[Nr] (rk[r] = {w[4r],w[4r+1],w[4r+2],w[4r+3]}); 1 cycle.
//   ROUND:  r = Nr-1 down to 0, one per cycle:
//           state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])),
//           InvMixColumns omitted when r==0. Then out<=state, done<=1.
//   DONE:   out and done held while start=1; start=0 -> IDLE, done=0 next edge, out retained.
//  Latency: done rises 4*(Nr+1)-Nk+Nr+2 edges after the first edge with start=1 in IDLE:
//   AES-128 = 52, AES-192 = 60, AES-256 = 68.
//  in/key sampled only in LOAD; later changes are ignored until the next request.
//  start=0 in any non-IDLE state: abort to IDLE on the next edge, done stays 0, out unchanged,
//   partial schedule discarded. A new request repeats the full key expansion.
//  rst asserted mid-operation: immediate return to reset values; no partial result is ever shown.
//  done never asserts without a complete Nr-round pass; out changes only on entry to DONE.
//  Round-key store: 4*(Nr+1) x 32-bit registers; indices never exceed 4*(Nr+1)-1.
// STRUCTURE
//  Shared package aes_pkg: forward S-box (key schedule), inverse S-box, Rcon[1..10],
//   gf_mul2 helper / xtime, and the state encoding for the FSM.
//  Sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns,
//   with a last_round input that bypasses InvMixColumns.
//  Key-schedule word generator and FSM live in this module.
// TESTING
//  1 AES-128: key 000102..0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff,
//    done at 52 cycles.
//  2 AES-192: key 000102..17, in dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, done at 60.
//  3 AES-256: key 000102..1f, in 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, done at 68.
//  4 Abort: drop start at cycle 20 of test 1, then reassert with the same inputs -> done low
//    throughout the abort, correct plaintext 52 cycles after reassertion.
//  5 Reset mid-run: rst pulse at cycle 30 -> out=0, done=0 immediately; the next request
//    completes correctly.
//  6 Round trip: random key/plaintext through the encryptor then this block (all three sizes,
//    >=100 vectors) -> out equals the original plaintext; in/key toggled after LOAD have no effect.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// aes_pkg - AES S-boxes, Rcon, GF(2^8) helpers and FSM encoding
// Rev 1.0
// ------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_ADDKEY = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bits {~x,3'b111} -: 8, so entry 0 is the leftmost byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant below 16, built from repeated doubling.
  function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = gf_mul2(a);
    x4 = gf_mul2(x2);
    x8 = gf_mul2(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^ gf_mul_c(a3, 4'h9),
            gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^ gf_mul_c(a3, 4'hd),
            gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^ gf_mul_c(a3, 4'hb),
            gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^ gf_mul_c(a3, 4'he)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ------------------------------------------------------------------------
// aes_inv_round - combinational AES inverse round, InvMixColumns bypassable
// Rev 1.0
// ------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] ark;
  logic [127:0] imc;

  // Byte k of the block is row k%4, column k/4; InvShiftRows rotates row r right by r.
  always_comb begin
    ark = '0;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = inv_sbox(state_in[127-8*(4*((c+4-r)%4)+r) -: 8])
                                  ^ rk[127-8*(4*c+r) -: 8];
      end
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  assign state_out = last_round ? ark : imc;

endmodule
`default_nettype wire

// File: rtl/decrypt_iterative.sv
`default_nettype none
// ------------------------------------------------------------------------
// decrypt_iterative - iterative AES inverse cipher, word-serial key schedule
// Rev 1.0
// ------------------------------------------------------------------------
module decrypt_iterative
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128,
  parameter int Nr      = 10,
  parameter int Nk      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       in,
  input  logic [KEY_LEN-1:0] key,
  output logic [127:0]       out,
  output logic               done
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int RW = $clog2(Nr + 1);

  state_e          fsm_q, fsm_d;
  logic [127:0]    blk_q, blk_d;
  logic [127:0]    out_q, out_d;
  logic            done_q, done_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      kmod_q, kmod_d;
  logic [3:0]      kdiv_q, kdiv_d;
  logic [31:0]     w_q [NW];
  logic [31:0]     w_d [NW];

  logic [IW-1:0]   rk_base;
  logic [127:0]    rk;
  logic [127:0]    round_out;
  logic [31:0]     w_prev, w_back, w_tmp;

  assign rk_base = IW'({rnd_q, 2'b00});
  assign rk      = {w_q[rk_base], w_q[rk_base + IW'(1)], w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};

  aes_inv_round u_round (
    .state_in   (blk_q),
    .rk         (rk),
    .last_round (rnd_q == '0),
    .state_out  (round_out)
  );

  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    out_d  = out_q;
    done_d = done_q;
    rnd_d  = rnd_q;
    idx_d  = idx_q;
    kmod_d = kmod_q;
    kdiv_d = kdiv_q;
    w_d    = w_q;
    w_prev = '0;
    w_back = '0;
    w_tmp  = '0;
    // Dropping start anywhere but IDLE abandons the request; out keeps its last value.
    if (fsm_q != ST_IDLE && !start) begin
      fsm_d  = ST_IDLE;
      done_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          done_d = 1'b0;
          if (start) fsm_d = ST_LOAD;
        end
        ST_LOAD: begin
          blk_d = in;
          for (int j = 0; j < Nk; j++) w_d[j] = key[KEY_LEN-1-32*j -: 32];
          idx_d  = IW'(Nk);
          kmod_d = 3'd0;
          kdiv_d = 4'd1;
          fsm_d  = ST_EXPAND;
        end
        ST_EXPAND: begin
          // kmod/kdiv track i%Nk and i/Nk without a divider.
          w_prev = w_q[idx_q - IW'(1)];
          w_back = w_q[idx_q - IW'(Nk)];
          if (kmod_q == 3'd0)
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(kdiv_q), 24'h0};
          else if (Nk > 6 && kmod_q == 3'd4)
            w_tmp = sub_word(w_prev);
          else
            w_tmp = w_prev;
          w_d[idx_q] = w_back ^ w_tmp;
          if (kmod_q == 3'(Nk - 1)) begin
            kmod_d = 3'd0;
            kdiv_d = kdiv_q + 4'd1;
          end else begin
            kmod_d = kmod_q + 3'd1;
          end
          if (idx_q == IW'(NW - 1)) begin
            fsm_d = ST_ADDKEY;
            rnd_d = RW'(Nr);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_ADDKEY: begin
          blk_d = blk_q ^ rk;
          rnd_d = rnd_q - RW'(1);
          fsm_d = ST_ROUND;
        end
        ST_ROUND: begin
          blk_d = round_out;
          if (rnd_q == '0) begin
            out_d  = round_out;
            done_d = 1'b1;
            fsm_d  = ST_DONE;
          end else begin
            rnd_d = rnd_q - RW'(1);
          end
        end
        ST_DONE: ;
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      blk_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      rnd_q  <= '0;
      idx_q  <= '0;
      kmod_q <= '0;
      kdiv_q <= '0;
      w_q    <= '{default: 32'h0};
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      out_q  <= out_d;
      done_q <= done_d;
      rnd_q  <= rnd_d;
      idx_q  <= idx_d;
      kmod_q <= kmod_d;
      kdiv_q <= kdiv_d;
      w_q    <= w_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decrypt_iterative.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_decrypt_iterative - bench for decrypt_iterative at all three key sizes
// Rev 1.0
// ------------------------------------------------------------------------
module tb_decrypt_iterative;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_s [3];
  logic [127:0] in_s    [3];
  logic [255:0] key_s   [3];
  logic [127:0] out_s   [3];
  logic         done_s  [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  decrypt_iterative #(.KEY_LEN(128), .Nr(10), .Nk(4)) u128 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in(in_s[0]), .key(key_s[0][255:128]),
    .out(out_s[0]), .done(done_s[0]));
  decrypt_iterative #(.KEY_LEN(192), .Nr(12), .Nk(6)) u192 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in(in_s[1]), .key(key_s[1][255:64]),
    .out(out_s[1]), .done(done_s[1]));
  decrypt_iterative #(.KEY_LEN(256), .Nr(14), .Nk(8)) u256 (
    .clk(clk), .rst(rst), .start(start_s[2]), .in(in_s[2]), .key(key_s[2]),
    .out(out_s[2]), .done(done_s[2]));

  // ---------------- reference model (forward cipher from first principles)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input int nk, input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) begin
      tmp  = w[b/4];
      s[b] = pt[127-8*b -: 8] ^ tmp[31-8*(b%4) -: 8];
    end
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) begin
        tmp  = w[4*r + b/4];
        s[b] = s[b] ^ tmp[31-8*(b%4) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // ---------------- checking helpers
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request: latency, result, out stability while busy, hold, and release.
  task automatic run_op(input int sz, input logic [255:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, input int lat, input bit scramble, input string tag);
    int           cyc;
    bit           early;
    logic [127:0] prev_out;
    @(negedge clk);
    key_s[sz]   = k;
    in_s[sz]    = ct;
    start_s[sz] = 1'b1;
    prev_out    = out_s[sz];
    early       = 1'b0;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_s[sz] === 1'b1) break;
      if (out_s[sz] !== prev_out) early = 1'b1;
      if (scramble) begin
        in_s[sz]  = rand128();
        key_s[sz] = rand256();
      end
    end
    check({tag, " latency"}, 128'(cyc), 128'(lat));
    check({tag, " plaintext"}, out_s[sz], pt);
    check({tag, " out stable while busy"}, 128'(early), 128'd0);
    @(posedge clk);
    #1;
    check({tag, " done held"}, {127'd0, done_s[sz]}, 128'd1);
    @(negedge clk);
    start_s[sz] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done clears"}, {127'd0, done_s[sz]}, 128'd0);
    check({tag, " out retained"}, out_s[sz], pt);
  endtask

  // ---------------- directed sequence
  initial begin
    int           lat;
    int           nk;
    bit           bad;
    logic [255:0] k;
    logic [127:0] p, c, prev;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      in_s[i]    = '0;
      key_s[i]   = '0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset out[%0d]", i), out_s[i], 128'd0);
      check($sformatf("reset done[%0d]", i), {127'd0, done_s[i]}, 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors
    run_op(0, K128, CT128, PT, 52, 1'b0, "kat128");
    run_op(1, K192, CT192, PT, 60, 1'b0, "kat192");
    run_op(2, K256, CT256, PT, 68, 1'b0, "kat256");

    // Abort at cycle 20, keep start low past the would-be finish, then rerun
    @(negedge clk);
    key_s[0] = K128; in_s[0] = CT128 ^ 128'h1; start_s[0] = 1'b1;
    prev = out_s[0];
    repeat (20) @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_s[0] !== 1'b0 || out_s[0] !== prev) bad = 1'b1;
    end
    check("abort quiet", 128'(bad), 128'd0);
    run_op(0, K128, CT128, PT, 52, 1'b0, "abort rerun");

    // Reset pulse at cycle 30 of an AES-128 request
    @(negedge clk);
    key_s[0] = K128; in_s[0] = CT128; start_s[0] = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out", out_s[0], 128'd0);
    check("midrst done", {127'd0, done_s[0]}, 128'd0);
    check("midrst out192", out_s[1], 128'd0);
    @(negedge clk);
    start_s[0] = 1'b0;
    rst = 1'b0;
    run_op(0, K128, CT128, PT, 52, 1'b0, "after rst");

    // Random round trips through the reference encryptor, inputs scrambled after LOAD
    for (int sz = 0; sz < 3; sz++) begin
      nk  = 4 + 2 * sz;
      lat = 4 * nk + 36;
      for (int v = 0; v < 35; v++) begin
        k = rand256();
        p = rand128();
        c = ref_encrypt(nk, k, p);
        run_op(sz, k, c, p, lat, 1'b1, $sformatf("rt%0d_%0d", 128 + 64 * sz, v));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
